// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback unit.
// Optional forwarding outputs are enabled by defining WB_FORWARD_EN.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    WRITE     = 2'd2
  } wb_state_t;

  // Register 15 aliases the PC and never lands in the register file.
  localparam logic [3:0] PC_REG = 4'hF;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

  // The wait counter only has to reach MEM_TIMEOUT-1.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int TIMEOUT_CNT_W_DEFAULT = timeout_cnt_w(MEM_TIMEOUT_DEFAULT);

endpackage

// File: rtl/writeback_unit_if.sv
// Execute, data-memory, register-file and decode-query signals of the writeback unit.
// Defining WB_FORWARD_EN adds the fwd_valid/fwd_addr/fwd_data bypass signals.
interface writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);

  logic              in_valid;
  logic              in_ready;
  logic              in_is_load;
  logic              in_wb_en;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_alu_result;

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              writeEnable;
  logic [REG_AW-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  logic              pc_we;
  logic [DATA_W-1:0] pc_wdata;

  logic [REG_AW-1:0] query_addr1;
  logic [REG_AW-1:0] query_addr2;
  logic              hazard;
  logic              load_fault;

`ifdef WB_FORWARD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Unit side.
  modport slave (
`ifdef WB_FORWARD_EN
    output fwd_valid, fwd_addr, fwd_data,
`endif
    input  in_valid, in_is_load, in_wb_en, in_rd, in_alu_result,
    output in_ready,
    output mem_req, mem_addr,
    input  mem_rvalid, mem_rdata,
    output writeEnable, writeAddr, writeData,
    output pc_we, pc_wdata,
    input  query_addr1, query_addr2,
    output hazard, load_fault
  );

  // Pipeline/memory/register-file side.
  modport master (
`ifdef WB_FORWARD_EN
    input  fwd_valid, fwd_addr, fwd_data,
`endif
    output in_valid, in_is_load, in_wb_en, in_rd, in_alu_result,
    input  in_ready,
    input  mem_req, mem_addr,
    output mem_rvalid, mem_rdata,
    input  writeEnable, writeAddr, writeData,
    input  pc_we, pc_wdata,
    output query_addr1, query_addr2,
    input  hazard, load_fault
  );

endinterface

// File: rtl/writeback_unit_scoreboard.sv
// Pending-destination mask with two-port RAW hazard lookup.
// With WB_FORWARD_EN, a register being written this cycle does not raise hazard.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
`ifdef WB_FORWARD_EN
  input  logic              fwd_en,
  input  logic [REG_AW-1:0] fwd_addr,
`endif
  input  logic [REG_AW-1:0] query_addr1,
  input  logic [REG_AW-1:0] query_addr2,
  output logic              hazard
);

  localparam int NREG   = 1 << REG_AW;
  localparam int PC_IDX = int'(PC_REG);

  logic [NREG-1:0] mask_reg;
  logic [NREG-1:0] mask_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] visible;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == PC_IDX) begin : g_pc
        assign set_vec[gi] = 1'b0;
      end else begin : g_gpr
        assign set_vec[gi] = set_en && (set_addr == REG_AW'(gi));
      end
      assign clr_vec[gi] = clr_en && (clr_addr == REG_AW'(gi));
      // An instruction being accepted this cycle already counts as pending.
`ifdef WB_FORWARD_EN
      assign visible[gi] = (mask_reg[gi] | set_vec[gi]) &
                           ~(fwd_en && (fwd_addr == REG_AW'(gi)));
`else
      assign visible[gi] = mask_reg[gi] | set_vec[gi];
`endif
    end
  endgenerate

  assign mask_next = (mask_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  assign hazard = (visible[query_addr1] && (query_addr1 != REG_AW'(PC_REG))) ||
                  (visible[query_addr2] && (query_addr2 != REG_AW'(PC_REG)));

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: ALU results written one cycle after accept, loads after a memory handshake.
// Defining WB_FORWARD_EN exposes the WRITE-cycle value as a decode bypass.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  writeback_unit_if.slave bus
);

  localparam int               CNT_W      = timeout_cnt_w(MEM_TIMEOUT);
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0);

  wb_state_t         state_reg, state_next;
  logic [REG_AW-1:0] rd_reg, rd_next;
  logic              wb_en_reg, wb_en_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              fault_next;
  logic              accept;

  logic              mem_req_reg;
  logic              write_en_reg;
  logic [REG_AW-1:0] write_addr_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic              pc_we_reg;
  logic [DATA_W-1:0] pc_wdata_reg;
  logic              fault_reg;

  logic              to_write;
  logic              is_pc_next;
  logic              sb_set_en;
  logic              sb_clr_en;

  always_comb begin
    state_next = state_reg;
    rd_next    = rd_reg;
    wb_en_next = wb_en_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    fault_next = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          rd_next    = bus.in_rd;
          wb_en_next = bus.in_wb_en;
          data_next  = bus.in_alu_result;
          if (bus.in_is_load) begin
            state_next = LOAD_WAIT;
            addr_next  = bus.in_alu_result;
            cnt_next   = '0;
          end else if (bus.in_wb_en) begin
            state_next = WRITE;
          end
        end
      end
      LOAD_WAIT: begin
        // Data arriving on the final allowed cycle still wins over the abort.
        if (bus.mem_rvalid) begin
          data_next  = bus.mem_rdata;
          state_next = WRITE;
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
          fault_next = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT_EN) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign to_write   = (state_next == WRITE);
  assign is_pc_next = (rd_next == REG_AW'(PC_REG));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rd_reg         <= '0;
      wb_en_reg      <= 1'b0;
      data_reg       <= '0;
      addr_reg       <= '0;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      pc_we_reg      <= 1'b0;
      pc_wdata_reg   <= '0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_reg       <= rd_next;
      wb_en_reg    <= wb_en_next;
      data_reg     <= data_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      mem_req_reg  <= (state_next == LOAD_WAIT);
      write_en_reg <= to_write && wb_en_next && !is_pc_next;
      pc_we_reg    <= to_write && wb_en_next && is_pc_next;
      fault_reg    <= fault_next;
      if (to_write) begin
        write_addr_reg <= rd_next;
        write_data_reg <= data_next;
      end
      if (to_write && wb_en_next && is_pc_next) begin
        pc_wdata_reg <= data_next;
      end
    end
  end

  // A pending bit retires either on its write or on a load abort.
  assign sb_set_en = accept && bus.in_wb_en;
  assign sb_clr_en = wb_en_reg && ((state_reg == WRITE) || fault_next);

  wb_scoreboard #(
    .REG_AW(REG_AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (sb_set_en),
    .set_addr   (bus.in_rd),
    .clr_en     (sb_clr_en),
    .clr_addr   (rd_reg),
`ifdef WB_FORWARD_EN
    .fwd_en     (write_en_reg),
    .fwd_addr   (write_addr_reg),
`endif
    .query_addr1(bus.query_addr1),
    .query_addr2(bus.query_addr2),
    .hazard     (bus.hazard)
  );

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_addr    = addr_reg;
  assign bus.writeEnable = write_en_reg;
  assign bus.writeAddr   = write_addr_reg;
  assign bus.writeData   = write_data_reg;
  assign bus.pc_we       = pc_we_reg;
  assign bus.pc_wdata    = pc_wdata_reg;
  assign bus.load_fault  = fault_reg;

`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = write_en_reg;
  assign bus.fwd_addr  = write_addr_reg;
  assign bus.fwd_data  = write_data_reg;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued at issue, a monitor checks them.
// Forward-path checks are compiled in when WB_FORWARD_EN is defined.
module tb_writeback_unit;

  logic clk;
  logic reset;

  int checks;
  int errors;

  typedef struct packed {
    logic        is_pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  writeback_unit_if #(.DATA_W(32), .REG_AW(4)) bus ();
  writeback_unit_if #(.DATA_W(32), .REG_AW(4)) bus_to ();

  writeback_unit #(.DATA_W(32), .REG_AW(4), .MEM_TIMEOUT(255)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  writeback_unit #(.DATA_W(32), .REG_AW(4), .MEM_TIMEOUT(4)) dut_to (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic load, input logic wb, input logic [3:0] rd,
                       input logic [31:0] val);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = load;
    bus.in_wb_en      = wb;
    bus.in_rd         = rd;
    bus.in_alu_result = val;
  endtask

  // Main-DUT monitor: every register-file or PC write must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (bus.writeEnable || bus.pc_we) begin
      a.is_pc = bus.pc_we;
      a.addr  = bus.pc_we ? 4'hF : bus.writeAddr;
      a.data  = bus.pc_we ? bus.pc_wdata : bus.writeData;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual pc=%0b addr=%0d data=%h required=no write",
                 a.is_pc, a.addr, a.data);
      end else begin
        e = exp_q.pop_front();
        if ((a !== e) || (bus.writeEnable && bus.pc_we)) begin
          errors++;
          $display("FAIL write actual we=%0b pc=%0b addr=%0d data=%h required pc=%0b addr=%0d data=%h",
                   bus.writeEnable, a.is_pc, a.addr, a.data, e.is_pc, e.addr, e.data);
        end else begin
          $display("ok   write pc=%0b addr=%0d data=%h", a.is_pc, a.addr, a.data);
        end
      end
    end
  end

  // The timeout instance never receives data, so it must never write.
  always @(negedge clk) begin
    if (bus_to.writeEnable || bus_to.pc_we) begin
      checks++;
      errors++;
      $display("FAIL timeout_unit_write actual we=%0b pc_we=%0b required=no write",
               bus_to.writeEnable, bus_to.pc_we);
    end
  end

  logic [3:0]  alu_rd  [3] = '{4'd3, 4'd7, 4'd0};
  logic [31:0] alu_val [3] = '{32'h0000_00AA, 32'h0BAD_F00D, 32'hFFFF_FFFF};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid = 0; bus.in_is_load = 0; bus.in_wb_en = 0; bus.in_rd = '0;
    bus.in_alu_result = '0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    bus.query_addr1 = '0; bus.query_addr2 = '0;
    bus_to.in_valid = 0; bus_to.in_is_load = 0; bus_to.in_wb_en = 0; bus_to.in_rd = '0;
    bus_to.in_alu_result = '0; bus_to.mem_rvalid = 0; bus_to.mem_rdata = '0;
    bus_to.query_addr1 = '0; bus_to.query_addr2 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_write_en", 32'(bus.writeEnable), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
    chk("rst_fault", 32'(bus.load_fault), 32'd0);
    chk("rst_hazard", 32'(bus.hazard), 32'd0);
    step();
    reset = 1'b0;

    // ALU writes: strobe one cycle after accept, hazard until the write retires.
    for (int i = 0; i < 3; i++) begin
      step();
      issue(1'b0, 1'b1, alu_rd[i], alu_val[i]);
      bus.query_addr1 = alu_rd[i];
      bus.query_addr2 = 4'd15;
      exp_q.push_back('{is_pc: 1'b0, addr: alu_rd[i], data: alu_val[i]});
      @(negedge clk);
      chk("alu_accept_ready", 32'(bus.in_ready), 32'd1);
      chk("alu_accept_hazard", 32'(bus.hazard), 32'd1);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("alu_write_ready", 32'(bus.in_ready), 32'd0);
`ifdef WB_FORWARD_EN
      chk("alu_write_hazard_fwd", 32'(bus.hazard), 32'd0);
      chk("fwd_valid", 32'(bus.fwd_valid), 32'd1);
      chk("fwd_addr", 32'(bus.fwd_addr), 32'(alu_rd[i]));
      chk("fwd_data", bus.fwd_data, alu_val[i]);
`else
      chk("alu_write_hazard", 32'(bus.hazard), 32'd1);
`endif
      step();
      @(negedge clk);
      chk("alu_after_hazard", 32'(bus.hazard), 32'd0);
    end

    // Load with a 5-cycle memory.
    step();
    issue(1'b1, 1'b1, 4'd5, 32'h0000_0100);
    bus.query_addr1 = 4'd5;
    exp_q.push_back('{is_pc: 1'b0, addr: 4'd5, data: 32'hDEAD_BEEF});
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("ld_mem_req", 32'(bus.mem_req), 32'd1);
      chk("ld_mem_addr", bus.mem_addr, 32'h0000_0100);
      chk("ld_in_ready", 32'(bus.in_ready), 32'd0);
      chk("ld_hazard", 32'(bus.hazard), 32'd1);
      if (c == 4) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
      end
      step();
    end
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ld_write_en", 32'(bus.writeEnable), 32'd1);
    chk("ld_req_dropped", 32'(bus.mem_req), 32'd0);
    step();
    @(negedge clk);
    chk("ld_ready_back", 32'(bus.in_ready), 32'd1);
    chk("ld_hazard_clear", 32'(bus.hazard), 32'd0);

    // Minimum-latency load: data in the first wait cycle, write at accept+2.
    step();
    issue(1'b1, 1'b1, 4'd9, 32'h0000_0044);
    exp_q.push_back('{is_pc: 1'b0, addr: 4'd9, data: 32'h1234_5678});
    step();
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ld_min_write_en", 32'(bus.writeEnable), 32'd1);
    chk("ld_min_addr", 32'(bus.writeAddr), 32'd9);

    // r15 goes to the PC redirect only and never raises hazard.
    step();
    issue(1'b0, 1'b1, 4'd15, 32'h0000_2000);
    bus.query_addr1 = 4'd15;
    bus.query_addr2 = 4'd15;
    exp_q.push_back('{is_pc: 1'b1, addr: 4'hF, data: 32'h0000_2000});
    @(negedge clk);
    chk("pc_accept_hazard", 32'(bus.hazard), 32'd0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pc_we", 32'(bus.pc_we), 32'd1);
    chk("pc_write_en", 32'(bus.writeEnable), 32'd0);
    chk("pc_write_hazard", 32'(bus.hazard), 32'd0);
    step();

    // Load with wb_en=0: handshake happens, no write, no hazard.
    step();
    issue(1'b1, 1'b0, 4'd6, 32'h0000_0040);
    bus.query_addr1 = 4'd6;
    @(negedge clk);
    chk("nowb_ld_hazard", 32'(bus.hazard), 32'd0);
    step();
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0055;
    @(negedge clk);
    chk("nowb_ld_req", 32'(bus.mem_req), 32'd1);
    chk("nowb_ld_addr", bus.mem_addr, 32'h0000_0040);
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("nowb_ld_no_write", 32'(bus.writeEnable | bus.pc_we), 32'd0);
    step();

    // Non-load with wb_en=0 stays in IDLE; stray mem_rvalid is ignored.
    step();
    issue(1'b0, 1'b0, 4'd2, 32'h0000_0077);
    bus.query_addr1 = 4'd2;
    bus.mem_rvalid  = 1'b1;
    step();
    bus.in_valid   = 1'b0;
    @(negedge clk);
    chk("nowb_alu_ready", 32'(bus.in_ready), 32'd1);
    chk("nowb_alu_hazard", 32'(bus.hazard), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;

    // Timeout instance: MEM_TIMEOUT=4 with no memory response.
    step();
    bus_to.in_valid      = 1'b1;
    bus_to.in_is_load    = 1'b1;
    bus_to.in_wb_en      = 1'b1;
    bus_to.in_rd         = 4'd4;
    bus_to.in_alu_result = 32'h0000_0200;
    bus_to.query_addr1   = 4'd4;
    step();
    bus_to.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("to_mem_req", 32'(bus_to.mem_req), 32'd1);
      chk("to_fault_low", 32'(bus_to.load_fault), 32'd0);
      chk("to_hazard", 32'(bus_to.hazard), 32'd1);
      step();
    end
    @(negedge clk);
    chk("to_fault_pulse", 32'(bus_to.load_fault), 32'd1);
    chk("to_req_dropped", 32'(bus_to.mem_req), 32'd0);
    chk("to_ready_back", 32'(bus_to.in_ready), 32'd1);
    chk("to_hazard_clear", 32'(bus_to.hazard), 32'd0);
    step();
    @(negedge clk);
    chk("to_fault_once", 32'(bus_to.load_fault), 32'd0);

    // Reset in LOAD_WAIT drops mem_req at once; a late response writes nothing.
    step();
    issue(1'b1, 1'b1, 4'd8, 32'h0000_0300);
    bus.query_addr1 = 4'd8;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstld_req_before", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstld_req_now", 32'(bus.mem_req), 32'd0);
    chk("rstld_hazard", 32'(bus.hazard), 32'd0);
    chk("rstld_ready", 32'(bus.in_ready), 32'd1);
    step();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_0001;
    step();
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstld_no_write", 32'(bus.writeEnable), 32'd0);

    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage that sits directly upstream of the register file and drives its write port (writeEnable, writeAddr, writeData).
- Accepts retiring instructions from execute: ALU results are written after one cycle; loads wait on a variable-latency data-memory handshake.
- Writes to r15 go to the PC redirect output, never to the register file.
- Maintains a pending-destination scoreboard so decode can stall on RAW hazards.

Parameters:
- DATA_W, 32, datapath width (register file is fixed at 32).
- REG_AW, 4, register address width; register 15 is the PC alias.
- MEM_TIMEOUT, 255, max cycles in LOAD_WAIT before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  execute presents a retiring instruction.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_is_load  input  1  instruction is a load.
- in_wb_en  input  1  instruction writes a destination register.
- in_rd  input  REG_AW  destination register.
- in_alu_result  input  DATA_W  ALU result, or load address when in_is_load.
- mem_req  output  1  load request, held until mem_rvalid.
- mem_addr  output  DATA_W  load address, stable while mem_req is high.
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  DATA_W  load data.
- writeEnable  output  1  register-file write strobe.
- writeAddr  output  REG_AW  register-file write address.
- writeData  output  DATA_W  register-file write data.
- pc_we  output  1  one-cycle PC redirect (rd==15).
- pc_wdata  output  DATA_W  redirect target.
- query_addr1, query_addr2  input  REG_AW  decode source registers.
- hazard  output  1  a source register is pending.
- load_fault  output  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; scoreboard clears.
  - All outputs 0 except in_ready, which is 1.
  - Reset during LOAD_WAIT drops mem_req immediately; a later mem_rvalid is ignored.
- FSM states:
  - IDLE: accept when in_valid && in_ready.
    - Non-load with in_wb_en: go to WRITE.
    - Load: go to LOAD_WAIT.
    - in_wb_en==0 and not a load: stay in IDLE, no write.
  - LOAD_WAIT:
    - mem_req=1 and mem_addr=latched address; in_ready=0.
    - On mem_rvalid: latch mem_rdata and go to WRITE.
    - When the cycle counter reaches MEM_TIMEOUT: pulse load_fault, clear the scoreboard bit, go to IDLE with no write.
  - WRITE, lasting one cycle:
    - rd!=15: writeEnable=1, writeAddr=rd, writeData=latched value.
    - rd==15: pc_we=1, pc_wdata=value, writeEnable=0.
    - Next state is IDLE.
- Latency from acceptance:
  - ALU op: write strobe in cycle +1.
  - Load: write strobe in the cycle after mem_rvalid. Minimum 2 cycles if mem_rvalid arrives in the first LOAD_WAIT cycle.
- All outputs are registered except hazard and in_ready, which are combinational.
- Scoreboard: 16-bit mask.
  - Set: bit rd is set on acceptance when in_wb_en=1.
  - Clear: the bit is cleared in the WRITE cycle.
  - Bit 15 is never set, because r15 reads always return PC+8.
  - hazard = mask[query_addr1] | mask[query_addr2], each term gated by query!=15.
  - Set and clear of the same bit in one cycle cannot occur (accept only in IDLE).
- A load with in_wb_en=0 still performs the handshake, then discards the data; no write, no pc_we.
- mem_rvalid outside LOAD_WAIT is ignored.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined:
  - Adds outputs fwd_valid (1), fwd_addr (REG_AW), fwd_data (DATA_W), mirroring the WRITE cycle.
  - hazard is suppressed for a source that matches a register being written in the current cycle. Decode muxes fwd_data instead of waiting one cycle for the registered file write.
- When undefined: no extra ports; hazard stays asserted through the WRITE cycle.

Decomposition:
- Package wb_pkg holds:
  - the state enum (IDLE, LOAD_WAIT, WRITE);
  - PC_REG = 4'hF;
  - timeout counter width derived from MEM_TIMEOUT.
- Natural sub-module: wb_scoreboard (mask register, set/clear, two-port hazard lookup, forward masking).

Test Plan:
- ALU write: in_valid, rd=3, result 0x0000_00AA -> next cycle writeEnable=1, writeAddr=3, writeData=0xAA; hazard for query 3 high in the accept cycle and low after WRITE.
- Load, 5-cycle memory: address 0x100 -> mem_req high for 5 cycles with mem_addr=0x100; mem_rdata=0xDEADBEEF -> write to rd the next cycle; in_ready low throughout.
- rd=15 ALU op, result 0x2000 -> pc_we=1, pc_wdata=0x2000, writeEnable=0; hazard never set for query 15.
- Timeout, MEM_TIMEOUT=4, mem_rvalid never asserted -> load_fault pulses once, no write, scoreboard bit cleared, in_ready returns high.
- Reset asserted mid-LOAD_WAIT -> mem_req=0 immediately; late mem_rvalid produces no write.
- WB_FORWARD_EN defined, rd=7 in WRITE with query_addr1=7 -> fwd_valid=1, fwd_data equals writeData, hazard=0.
